uart_tx: RTL and testbench



---
 rtl/uart_tx.sv | 146 ++++++++++++++
 tb/tb_uart_tx.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed by a valid/ready byte handshake; TX_Ready rises at the end of each frame.
// Define UART_TX_PARITY_EN to insert an even parity bit between the data bits and the stop bit.
module uart_tx #(
  parameter int unsigned FREQ_CLK = 100000000,
  parameter int unsigned TX_SPEED = 115200
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       TX_Valid,
  input  logic [7:0] TX_DataIn,
  output logic       TX_Ready,
  output logic       TXD
);

  localparam int unsigned BIT_CYCLES = FREQ_CLK / TX_SPEED;
  localparam int unsigned CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned BIT_W      = 3;
  localparam logic [CNT_W-1:0] BAUD_TC  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(7);

  if (BIT_CYCLES < 2) begin : g_bad_baud
    $error("uart_tx: FREQ_CLK / TX_SPEED must be at least 2");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             ready_q, ready_d;
  logic             baud_tc;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign baud_tc  = (baud_q == BAUD_TC);
  assign TXD      = txd_q;
  assign TX_Ready = ready_q;

  // State and datapath registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
      ready_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      ready_q  <= ready_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Next-state and next-output logic; every bit period ends on the baud terminal count
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    txd_d    = txd_q;
    ready_d  = ready_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    if (state_q != IDLE) begin
      baud_d = baud_tc ? '0 : baud_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        txd_d   = 1'b1;
        ready_d = 1'b1;
        if (TX_Valid) begin
          shift_d = TX_DataIn;
          baud_d  = '0;
          txd_d   = 1'b0;
          ready_d = 1'b0;
          state_d = START;
`ifdef UART_TX_PARITY_EN
          parity_d = ^TX_DataIn;
`endif
        end
      end
      START: begin
        if (baud_tc) begin
          txd_d   = shift_q[0];
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_tc) begin
          if (bit_q != LAST_BIT) begin
            shift_d = {1'b0, shift_q[7:1]};
            txd_d   = shift_q[1];
            bit_d   = bit_q + BIT_W'(1);
          end else begin
`ifdef UART_TX_PARITY_EN
            txd_d   = parity_q;
            state_d = PARITY;
`else
            txd_d   = 1'b1;
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_tc) begin
          txd_d   = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (baud_tc) begin
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Randomised self-checking bench for uart_tx at BIT_CYCLES=10; honours UART_TX_PARITY_EN.
module tb_uart_tx;

  localparam int unsigned FREQ_CLK = 1000000;
  localparam int unsigned TX_SPEED = 100000;
  localparam int BITC = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int BOUND = 300;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       TX_Valid = 1'b0;
  logic [7:0] TX_DataIn = 8'h00;
  logic       TX_Ready;
  logic       TXD;

  int checks = 0;
  int errors = 0;

  uart_tx #(.FREQ_CLK(FREQ_CLK), .TX_SPEED(TX_SPEED)) dut (
    .Clk(Clk), .Rst(Rst), .TX_Valid(TX_Valid), .TX_DataIn(TX_DataIn),
    .TX_Ready(TX_Ready), .TXD(TXD)
  );

  always #5 Clk = ~Clk;

  // Expected line levels per bit slot: start, data LSB first, optional even parity, stop
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic [10:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
    f[9] = ^b;
`endif
    return f;
  endfunction

  // Pulse TX_Valid for one edge; returns at the negedge just after the accept edge
  task automatic send_pulse(input logic [7:0] b);
    TX_Valid  = 1'b1;
    TX_DataIn = b;
    @(negedge Clk);
    TX_Valid  = 1'b0;
  endtask

  // Samples TXD at bit centres until TX_Ready returns high (called at the first negedge of a frame)
  task automatic capture_frame(output logic [10:0] bits, output int low, output int tail,
                               output logic timed_out);
    bits = '1;
    low = 0;
    tail = 0;
    timed_out = 1'b1;
    for (int c = 0; c < BOUND; c++) begin
      if (TX_Ready === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      low++;
      if (TXD === 1'b1) tail++;
      else tail = 0;
      if ((c % BITC) == BITC / 2 && (c / BITC) < NB) bits[c / BITC] = TXD;
      @(negedge Clk);
    end
  endtask

  task automatic test_reset;
    int bad;
    @(negedge Clk);
    checks++;
    if (TXD !== 1'b1 || TX_Ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_values: TXD=%b TX_Ready=%b expected 1 1", TXD, TX_Ready);
    end
    repeat (4) @(negedge Clk);
    Rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (TXD !== 1'b1 || TX_Ready !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_idle: %0d non-idle cycles, expected 0", bad);
    end
  endtask

  task automatic test_single_byte;
    logic [10:0] bits;
    int low, tail;
    logic to;
    send_pulse(8'h77);
    capture_frame(bits, low, tail, to);
    checks++;
    if (to || low != NB * BITC) begin
      errors++;
      $display("FAIL single_ready_low: got %0d cycles (timeout=%b) expected %0d", low, to, NB * BITC);
    end
    checks++;
    if (bits !== model_frame(8'h77)) begin
      errors++;
      $display("FAIL single_bits: got %b expected %b", bits, model_frame(8'h77));
    end
    checks++;
    if (TXD !== 1'b1) begin
      errors++;
      $display("FAIL single_idle_line: TXD=%b expected 1", TXD);
    end
    repeat (3) @(negedge Clk);
  endtask

  task automatic test_back_to_back;
    logic [10:0] bits1, bits2;
    int low1, low2, tail1, tail2, high;
    logic to1, to2;
    TX_Valid  = 1'b1;
    TX_DataIn = 8'h55;
    @(negedge Clk);
    TX_DataIn = 8'hBB;
    capture_frame(bits1, low1, tail1, to1);
    high = 0;
    for (int i = 0; i < 5 && TX_Ready === 1'b1; i++) begin
      high++;
      @(negedge Clk);
    end
    TX_Valid = 1'b0;
    capture_frame(bits2, low2, tail2, to2);
    checks++;
    if (to1 || bits1 !== model_frame(8'h55)) begin
      errors++;
      $display("FAIL b2b_first: got %b expected %b", bits1, model_frame(8'h55));
    end
    checks++;
    if (high != 1) begin
      errors++;
      $display("FAIL b2b_ready_gap: got %0d high cycles expected 1", high);
    end
    checks++;
    if (tail1 + high != BITC + 1) begin
      errors++;
      $display("FAIL b2b_stop_len: got %0d expected %0d", tail1 + high, BITC + 1);
    end
    checks++;
    if (to2 || low2 != NB * BITC || bits2 !== model_frame(8'hBB)) begin
      errors++;
      $display("FAIL b2b_second: got %b low=%0d expected %b low=%0d", bits2, low2,
               model_frame(8'hBB), NB * BITC);
    end
    repeat (3) @(negedge Clk);
  endtask

  task automatic test_busy_ignore;
    logic [10:0] bits;
    int low, tail, bad;
    logic to;
    send_pulse(8'hAA);
    fork
      capture_frame(bits, low, tail, to);
      begin
        repeat (40) @(negedge Clk);
        TX_Valid  = 1'b1;
        TX_DataIn = 8'h03;
        @(negedge Clk);
        TX_Valid  = 1'b0;
      end
    join
    checks++;
    if (to || low != NB * BITC || bits !== model_frame(8'hAA)) begin
      errors++;
      $display("FAIL busy_frame: got %b low=%0d expected %b", bits, low, model_frame(8'hAA));
    end
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (TXD !== 1'b1 || TX_Ready !== 1'b1) bad++;
      @(negedge Clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL busy_no_extra_frame: %0d active cycles expected 0", bad);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [10:0] bits;
    int low, tail;
    logic to;
    send_pulse(8'hCC);
    repeat (35) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    checks++;
    if (TXD !== 1'b1 || TX_Ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_values: TXD=%b TX_Ready=%b expected 1 1", TXD, TX_Ready);
    end
    // Valid on a reset edge must be dropped
    TX_Valid  = 1'b1;
    TX_DataIn = 8'hE1;
    @(negedge Clk);
    Rst = 1'b0;
    TX_Valid = 1'b0;
    @(negedge Clk);
    checks++;
    if (TX_Ready !== 1'b1 || TXD !== 1'b1) begin
      errors++;
      $display("FAIL reset_beats_valid: TX_Ready=%b TXD=%b expected 1 1", TX_Ready, TXD);
    end
    send_pulse(8'h0F);
    capture_frame(bits, low, tail, to);
    checks++;
    if (to || low != NB * BITC || bits !== model_frame(8'h0F)) begin
      errors++;
      $display("FAIL midreset_resend: got %b low=%0d expected %b", bits, low, model_frame(8'h0F));
    end
    repeat (2) @(negedge Clk);
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    logic [10:0] bits;
    int low, tail;
    logic to;
    logic [7:0] vals [2];
    logic       par [2];
    vals[0] = 8'h01; par[0] = 1'b1;
    vals[1] = 8'h03; par[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      send_pulse(vals[k]);
      capture_frame(bits, low, tail, to);
      checks++;
      if (to || low != 110 || bits[9] !== par[k]) begin
        errors++;
        $display("FAIL parity_%h: parity=%b low=%0d expected %b 110", vals[k], bits[9], low, par[k]);
      end
      repeat (2) @(negedge Clk);
    end
  endtask
`endif

  task automatic test_random;
    logic [10:0] bits;
    int low, tail;
    logic to;
    logic [7:0] b;
    for (int n = 0; n < 8; n++) begin
      b = 8'($urandom);
      send_pulse(b);
      capture_frame(bits, low, tail, to);
      checks++;
      if (to || low != NB * BITC || bits !== model_frame(b)) begin
        errors++;
        $display("FAIL random_%0d: byte %h got %b low=%0d expected %b low=%0d", n, b, bits, low,
                 model_frame(b), NB * BITC);
      end
      repeat ($urandom_range(3)) @(negedge Clk);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
